// File: rtl/mic_frame_sched.sv
// Capture scheduler between the I2S microphone decoder and the HPS Avalon-MM
// slave. Whole frames of NCH samples are queued in a DEPTH-frame FIFO and the
// HPS drains them one sample per DATA read. A fill-threshold level interrupt
// and a saturating overrun counter support the software driver.
module mic_frame_sched #(
    parameter int NCH    = 4,
    parameter int SW     = 24,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_valid,
    input  logic [NCH*SW-1:0]   frame_data,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [2:0]          address,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [FW-1:0]  FILL_FULL   = FW'(DEPTH);
    localparam logic [CW-1:0]  CH_LAST     = CW'(NCH - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Samples are two's complement; the bus word carries them sign-extended.
    function automatic logic [31:0] sext(input logic signed [SW-1:0] s);
        return 32'(s);
    endfunction

    // Overrun counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t                state_q, state_d;
    logic [SCW-1:0]        settle_cnt_q;
    logic                  ctrl_en_q, ctrl_irq_en_q;
    logic [4:0]            thresh_q;
    logic [NCH*SW-1:0]     mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [FW-1:0]         fill_q;
    logic [CW-1:0]         ch_idx_q;
    logic [15:0]           ovr_cnt_q;
    logic                  ovr_sticky_q, udf_sticky_q;
    logic [31:0]           rd_mux;

    logic sel_rd, sel_wr, ctrl_wr, flush;
    logic data_rd, status_rd, ovr_rd;
    logic rd_ok, pop, push_req, push_ok, overrun, underflow;
    logic fifo_empty, fifo_full;
    logic [7:0] fill8, thr_eff;
    logic signed [SW-1:0] rd_sample;
    logic unused_wdata;

    assign sel_rd    = chipselect & read;
    assign sel_wr    = chipselect & write;
    assign ctrl_wr   = sel_wr & (address == 3'd2);
    assign flush     = ctrl_wr & writedata[2];
    assign data_rd   = sel_rd & (address == 3'd0);
    assign status_rd = sel_rd & (address == 3'd1);
    assign ovr_rd    = sel_rd & (address == 3'd3);

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_FULL);

    // A pop completes when the last channel of the head frame is read; that
    // frees a slot in the same cycle, so a push on a full FIFO still lands.
    assign rd_ok     = data_rd & ~fifo_empty;
    assign underflow = data_rd & fifo_empty;
    assign pop       = rd_ok & (ch_idx_q == CH_LAST);
    assign push_req  = frame_valid & (state_q == ST_RUN) & ~flush;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign overrun   = push_req & fifo_full & ~pop;

    assign rd_sample = mem[rd_ptr_q][ch_idx_q*SW +: SW];
    assign fill8     = 8'(fill_q);
    assign thr_eff   = (thresh_q == 5'd0) ? 8'd1 : 8'(thresh_q);

    assign unused_wdata = ^{writedata[31:13], writedata[7:3]};

    // State register for the enable / mic start-up sequencer.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_OFF;
        else     state_q <= state_d;
    end

    // Next-state logic: settle frames are swallowed before capture starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (ctrl_en_q) state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!ctrl_en_q) state_d = ST_OFF;
                else if (frame_valid && (settle_cnt_q == SETTLE_LAST)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctrl_en_q) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Counts discarded frames while settling; idle at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_SETTLE)) settle_cnt_q <= '0;
        else if (frame_valid)              settle_cnt_q <= settle_cnt_q + 1'b1;
    end

    // CTRL register; flush is an action and is not stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_q     <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            thresh_q      <= '0;
        end else if (ctrl_wr) begin
            ctrl_en_q     <= writedata[0];
            ctrl_irq_en_q <= writedata[1];
            thresh_q      <= writedata[12:8];
        end
    end

    // Frame storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= frame_data;
    end

    // FIFO pointers, fill level and channel cursor within the head frame.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ch_idx_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      fill_q <= fill_q + 1'b1;
            else if (pop && !push_ok) fill_q <= fill_q - 1'b1;
            if (rd_ok) ch_idx_q <= pop ? '0 : ch_idx_q + 1'b1;
        end
    end

    // Sticky error flags and overrun counter; a new event wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
            ovr_cnt_q    <= '0;
        end else begin
            ovr_sticky_q <= overrun   | (ovr_sticky_q & ~status_rd);
            udf_sticky_q <= underflow | (udf_sticky_q & ~status_rd);
            if (ovr_rd)       ovr_cnt_q <= overrun ? 16'd1 : 16'd0;
            else if (overrun) ovr_cnt_q <= sat_inc(ovr_cnt_q);
        end
    end

    // Register read mux built from pre-edge values.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = rd_ok ? sext(rd_sample) : 32'd0;
            3'd1: rd_mux = {18'd0, state_q, udf_sticky_q, ovr_sticky_q,
                            fifo_full, fifo_empty, fill8};
            3'd2: rd_mux = {19'd0, thresh_q, 5'd0, 1'b0, ctrl_irq_en_q, ctrl_en_q};
            3'd3: rd_mux = {16'd0, ovr_cnt_q};
            default: rd_mux = '0;
        endcase
    end

    // Read data register, one cycle of latency after the read strobe.
    always_ff @(posedge clk) begin
        if (rst)         readdata <= '0;
        else if (sel_rd) readdata <= rd_mux;
    end

    // Level interrupt from registered fill, so it trails fill by one cycle.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= ctrl_irq_en_q & (state_q != ST_OFF) & (fill8 >= thr_eff);
    end

endmodule

// File: tb/tb_mic_frame_sched.sv
// Directed bench for mic_frame_sched: settle drop, sign extension, irq
// threshold, overrun, full-with-pop, pointer wrap, underflow, flush and reset.
module tb_mic_frame_sched;

    localparam int NCH = 4;
    localparam int SW  = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_valid;
    logic [NCH*SW-1:0] frame_data;
    logic              chipselect, read, write;
    logic [2:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NCH*SW-1:0] q[$];
    logic [31:0] d;

    mic_frame_sched #(.NCH(4), .SW(24), .DEPTH(16), .SETTLE(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .chipselect  (chipselect),
        .read        (read),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*SW-1:0] mk(input int k);
        logic [NCH*SW-1:0] f;
        for (int i = 0; i < NCH; i++)
            f[i*SW +: SW] = 24'(k * 256 + i) ^ ((i % 2 == 1) ? 24'h800000 : 24'h0);
        return f;
    endfunction

    function automatic logic [31:0] sx(input logic [SW-1:0] v);
        return {{(32-SW){v[SW-1]}}, v};
    endfunction

    task automatic idle();
        frame_valid = 1'b0;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        address     = 3'd0;
        writedata   = 32'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        idle();
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        idle();
        v = readdata;
    endtask

    task automatic send_frame(input logic [NCH*SW-1:0] f);
        @(negedge clk);
        frame_valid = 1'b1; frame_data = f;
        @(negedge clk);
        idle();
    endtask

    task automatic read_with_frame(input logic [NCH*SW-1:0] f, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 3'd0;
        frame_valid = 1'b1; frame_data = f;
        @(negedge clk);
        idle();
        v = readdata;
    endtask

    task automatic write_with_frame(input logic [31:0] w, input logic [NCH*SW-1:0] f);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 3'd2; writedata = w;
        frame_valid = 1'b1; frame_data = f;
        @(negedge clk);
        idle();
    endtask

    // Reads one full frame and compares it with the head of the model queue.
    task automatic read_frame_chk(input string tag);
        logic [NCH*SW-1:0] fr;
        logic [31:0] v;
        if (q.size() == 0) begin
            chk({tag, "_model_empty"}, 32'd1, 32'd0);
            return;
        end
        fr = q.pop_front();
        for (int c = 0; c < NCH; c++) begin
            reg_read(3'd0, v);
            chk($sformatf("%s_ch%0d", tag, c), v, sx(fr[c*SW +: SW]));
        end
    endtask

    initial begin
        logic [NCH*SW-1:0] fr;
        idle();
        frame_data = '0;
        rst = 1'b1;
        tick(3);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        reg_read(3'd1, d); chk("rst_status", d, 32'h0000_0100);
        reg_read(3'd2, d); chk("rst_ctrl", d, 32'd0);
        reg_read(3'd3, d); chk("rst_ovr", d, 32'd0);
        reg_read(3'd5, d); chk("rst_addr5", d, 32'd0);

        // T1: two settle frames dropped, third stored, sign extension
        reg_write(3'd2, 32'h1);
        tick(2);
        reg_read(3'd1, d); chk("t1_status_settle", d, 32'h0000_1100);
        fr = {24'h7FFFFF, 24'hFFFFFF, 24'h000002, 24'h000001};
        send_frame(fr);
        send_frame(fr);
        send_frame(fr);
        reg_read(3'd1, d); chk("t1_status_fill1", d, 32'h0000_2001);
        reg_read(3'd0, d); chk("t1_s0", d, 32'h0000_0001);
        reg_read(3'd0, d); chk("t1_s1", d, 32'h0000_0002);
        reg_read(3'd0, d); chk("t1_s2", d, 32'hFFFF_FFFF);
        reg_read(3'd0, d); chk("t1_s3", d, 32'h007F_FFFF);
        reg_read(3'd1, d); chk("t1_status_empty", d, 32'h0000_2100);

        // T2: threshold 4 interrupt, one cycle after the fill change
        reg_write(3'd2, 32'h0000_0403);
        for (int k = 0; k < 4; k++) begin
            send_frame(mk(k));
            q.push_back(mk(k));
        end
        chk("t2_irq_lag", {31'd0, irq}, 32'd0);
        tick(1);
        chk("t2_irq_set", {31'd0, irq}, 32'd1);
        read_frame_chk("t2_f0");
        chk("t2_irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        chk("t2_irq_clr", {31'd0, irq}, 32'd0);
        for (int k = 1; k < 4; k++) read_frame_chk("t2_drain");

        // T3: 18 frames into a 16-deep FIFO
        reg_write(3'd2, 32'h1);
        for (int k = 0; k < 18; k++) begin
            send_frame(mk(100 + k));
            if (k < 16) q.push_back(mk(100 + k));
        end
        reg_read(3'd1, d); chk("t3_status_full", d, 32'h0000_2610);
        chk("t3_irq_off", {31'd0, irq}, 32'd0);
        reg_read(3'd3, d); chk("t3_ovr", d, 32'd2);
        reg_read(3'd3, d); chk("t3_ovr_cleared", d, 32'd0);
        reg_read(3'd1, d); chk("t3_status_sticky_clr", d, 32'h0000_2210);

        // T4: push on full in the same cycle as the popping read
        fr = q[0];
        for (int c = 0; c < 3; c++) begin
            reg_read(3'd0, d);
            chk($sformatf("t4_head_ch%0d", c), d, sx(fr[c*SW +: SW]));
        end
        read_with_frame(mk(200), d);
        chk("t4_head_ch3", d, sx(fr[3*SW +: SW]));
        void'(q.pop_front());
        q.push_back(mk(200));
        reg_read(3'd1, d); chk("t4_status_still_full", d, 32'h0000_2210);
        reg_read(3'd3, d); chk("t4_ovr_unchanged", d, 32'd0);
        for (int k = 0; k < 16; k++) read_frame_chk("t4_drain");
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 8; j++) begin
                send_frame(mk(300 + b * 8 + j));
                q.push_back(mk(300 + b * 8 + j));
            end
            for (int j = 0; j < 8; j++) read_frame_chk($sformatf("t4_wrap%0d", b));
        end
        reg_read(3'd1, d); chk("t4_status_end", d, 32'h0000_2100);

        // T5: underflow
        reg_read(3'd0, d); chk("t5_empty_read", d, 32'd0);
        reg_read(3'd1, d); chk("t5_status_udf", d, 32'h0000_2900);
        reg_read(3'd1, d); chk("t5_status_udf_clr", d, 32'h0000_2100);

        // T6: flush with a colliding frame, then reset mid-frame
        for (int k = 0; k < 5; k++) send_frame(mk(400 + k));
        reg_read(3'd1, d); chk("t6_status_fill5", d, 32'h0000_2005);
        write_with_frame(32'h5, mk(999));
        q.delete();
        reg_read(3'd1, d); chk("t6_status_flushed", d, 32'h0000_2100);
        reg_read(3'd3, d); chk("t6_ovr", d, 32'd0);
        reg_read(3'd2, d); chk("t6_ctrl", d, 32'h0000_0001);
        send_frame(mk(500));
        q.push_back(mk(500));
        read_frame_chk("t6_after_flush");

        send_frame(mk(600));
        send_frame(mk(601));
        fr = mk(600);
        reg_read(3'd0, d); chk("t6_partial_ch0", d, sx(fr[0 +: SW]));
        reg_read(3'd0, d); chk("t6_partial_ch1", d, sx(fr[SW +: SW]));
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("t6_rst_readdata", readdata, 32'd0);
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        reg_read(3'd1, d); chk("t6_rst_status", d, 32'h0000_0100);
        reg_read(3'd2, d); chk("t6_rst_ctrl", d, 32'd0);
        reg_read(3'd3, d); chk("t6_rst_ovr", d, 32'd0);
        q.delete();
        reg_write(3'd2, 32'h1);
        tick(2);
        send_frame(mk(1));
        send_frame(mk(2));
        send_frame(mk(700));
        q.push_back(mk(700));
        read_frame_chk("t6_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
